jt51_csr_ch_q: RTL and testbench

Parametrised channel control-register file for the JT51 FM core: stores RL/FB/CON/KC/KF/AMS/PMS for `CH` channels and presents them one channel per `cen` in rotating slot order to the operator/phase pipeline. CPU writes go into a small in-order pending queue. Each queued write is committed when its target channel's slot comes round, so the write path no longer has to be slot-aligned. Sits between the register decoder (`jt51_reg`) and the phase/envelope pipeline, where it replaces the fixed 8-channel shift-register store.

---
 rtl/jt51_pkg.sv | 53 +++++
 rtl/jt51_csr_wq.sv | 53 +++++
 rtl/jt51_csr_ch_q.sv | 110 +++++++++++
 tb/tb_jt51_csr_ch_q.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_pkg.sv
// Shared JT51 channel-CSR definitions: field widths, packed channel word
// layout, write-group encodings and the field-merge function.
package jt51_pkg;

  localparam int RL_W  = 2;
  localparam int FB_W  = 3;
  localparam int CON_W = 3;
  localparam int KC_W  = 7;
  localparam int KF_W  = 6;
  localparam int AMS_W = 2;
  localparam int PMS_W = 3;
  localparam int CHWORD_W = RL_W + FB_W + CON_W + KC_W + KF_W + AMS_W + PMS_W;

  typedef enum logic [1:0] {
    GRP_RLFBCON = 2'd0,
    GRP_KC      = 2'd1,
    GRP_KF      = 2'd2,
    GRP_PMSAMS  = 2'd3
  } wr_grp_e;

  // Packed MSB..LSB as {rl, fb, con, kc, kf, ams, pms}
  typedef struct packed {
    logic [RL_W-1:0]  rl;
    logic [FB_W-1:0]  fb;
    logic [CON_W-1:0] con;
    logic [KC_W-1:0]  kc;
    logic [KF_W-1:0]  kf;
    logic [AMS_W-1:0] ams;
    logic [PMS_W-1:0] pms;
  } ch_word_t;

  // Replace only the fields selected by grp; all other bits pass through.
  function automatic ch_word_t ch_merge(ch_word_t w, wr_grp_e grp, logic [7:0] d);
    ch_word_t r;
    r = w;
    case (grp)
      GRP_RLFBCON: begin
        r.rl  = d[7:6];
        r.fb  = d[5:3];
        r.con = d[2:0];
      end
      GRP_KC:      r.kc = d[6:0];
      GRP_KF:      r.kf = d[7:2];
      GRP_PMSAMS: begin
        r.pms = d[6:4];
        r.ams = d[1:0];
      end
      default:     r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jt51_csr_wq.sv
// Generic in-order write queue: W-bit entries, D deep, registered count.
module jt51_csr_wq #(
  parameter int W  = 8,
  parameter int D  = 2,
  parameter int CW = $clog2(D + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam logic [AW-1:0] LAST = AW'(D - 1);
  localparam logic [CW-1:0] DEPTH = CW'(D);

  logic [W-1:0]  buf_q [D];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH);
  assign count_o = cnt_q;
  assign head_o  = buf_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (cnt_q != '0);

  // Storage, pointers and occupancy; pointers wrap at D for any depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < D; i++) buf_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        buf_q[wr_q] <= din_i;
        wr_q        <= (wr_q == LAST) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == LAST) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/jt51_csr_ch_q.sv
// JT51 channel control-register file with a pending-write queue. Fields are
// presented one channel per cen in rotating slot order; queued CPU writes
// commit when their channel's slot comes round and bypass onto the output.
module jt51_csr_ch_q
  import jt51_pkg::*;
#(
  parameter int CH  = 8,
  parameter int CHW = $clog2(CH),
  parameter int QD  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [7:0]       din,
  input  logic             wr,
  input  logic [1:0]       wr_grp,
  input  logic [CHW-1:0]   wr_ch,
  output logic             busy,
  output logic             ovf,
  output logic [CHW-1:0]   slot,
  output logic [RL_W-1:0]  rl,
  output logic [FB_W-1:0]  fb,
  output logic [CON_W-1:0] con,
  output logic [KC_W-1:0]  kc,
  output logic [KF_W-1:0]  kf,
  output logic [AMS_W-1:0] ams,
  output logic [PMS_W-1:0] pms
);

  localparam int EW = 2 + CHW + 8;
  localparam int CW = $clog2(QD + 1);
  localparam logic [CHW:0]   CH_L = (CHW + 1)'(CH);
  localparam logic [CHW-1:0] LAST = CHW'(CH - 1);

  ch_word_t       mem_q [CH];
  ch_word_t       out_q, word_d;
  logic [CHW-1:0] ptr_q, ptr_d, slot_q;
  logic           ovf_q;

  logic [EW-1:0]  push_ent, head;
  logic [CW-1:0]  count;
  logic           full, wr_ok, push, drop, hit, pop;
  logic [1:0]     h_grp;
  logic [CHW-1:0] h_ch;
  logic [7:0]     h_dat;

  assign wr_ok    = ({1'b0, wr_ch} < CH_L);
  assign push     = wr && !full && wr_ok;
  assign drop     = wr && !push;
  assign push_ent = {wr_grp, wr_ch, din};
  assign h_grp    = head[EW-1 -: 2];
  assign h_ch     = head[8 +: CHW];
  assign h_dat    = head[7:0];
  assign hit      = (count != '0) && (h_ch == ptr_q);
  assign pop      = cen && hit;

  jt51_csr_wq #(
    .W (EW),
    .D (QD)
  ) u_wq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_ent),
    .head_o  (head),
    .count_o (count),
    .full_o  (full)
  );

  // Word for the current slot with the head write merged in when it targets it.
  always_comb begin
    word_d = mem_q[ptr_q];
    if (hit) word_d = ch_merge(word_d, wr_grp_e'(h_grp), h_dat);
    ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
  end

  // Slot rotation, write-back and output register, advancing only on cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH; i++) mem_q[i] <= '0;
      out_q  <= '0;
      slot_q <= '0;
      ptr_q  <= '0;
    end else if (cen) begin
      mem_q[ptr_q] <= word_d;
      out_q        <= word_d;
      slot_q       <= ptr_q;
      ptr_q        <= ptr_d;
    end
  end

  // Sticky flag for writes refused because the queue was full or channel invalid.
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

  assign busy = full;
  assign ovf  = ovf_q;
  assign slot = slot_q;
  assign rl   = out_q.rl;
  assign fb   = out_q.fb;
  assign con  = out_q.con;
  assign kc   = out_q.kc;
  assign kf   = out_q.kf;
  assign ams  = out_q.ams;
  assign pms  = out_q.pms;

endmodule

// File: tb/tb_jt51_csr_ch_q.sv
// Self-checking bench for jt51_csr_ch_q: an 8-channel instance checked by a
// reference model through a scoreboard, plus a 6-channel instance for wrap
// and invalid-channel behaviour.
module tb_jt51_csr_ch_q;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen = 1'b0;
  logic [7:0] din = '0;
  logic       wr = 1'b0;
  logic [1:0] wr_grp = '0;
  logic [2:0] wr_ch = '0;
  logic       busy, ovf;
  logic [2:0] slot;
  logic [1:0] rl;
  logic [2:0] fb, con;
  logic [6:0] kc;
  logic [5:0] kf;
  logic [1:0] ams;
  logic [2:0] pms;

  logic       cen6 = 1'b0;
  logic [7:0] din6 = '0;
  logic       wr6 = 1'b0;
  logic [1:0] wr_grp6 = '0;
  logic [2:0] wr_ch6 = '0;
  logic       busy6, ovf6;
  logic [2:0] slot6;
  logic [1:0] rl6;
  logic [2:0] fb6, con6;
  logic [6:0] kc6;
  logic [5:0] kf6;
  logic [1:0] ams6;
  logic [2:0] pms6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jt51_csr_ch_q #(.CH(8), .QD(2)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .wr(wr), .wr_grp(wr_grp),
    .wr_ch(wr_ch), .busy(busy), .ovf(ovf), .slot(slot), .rl(rl), .fb(fb),
    .con(con), .kc(kc), .kf(kf), .ams(ams), .pms(pms)
  );

  jt51_csr_ch_q #(.CH(6), .QD(2)) dut6 (
    .clk(clk), .rst(rst), .cen(cen6), .din(din6), .wr(wr6), .wr_grp(wr_grp6),
    .wr_ch(wr_ch6), .busy(busy6), .ovf(ovf6), .slot(slot6), .rl(rl6), .fb(fb6),
    .con(con6), .kc(kc6), .kf(kf6), .ams(ams6), .pms(pms6)
  );

  // Reference model of the 8-channel instance
  typedef struct packed {
    logic [1:0] rl;
    logic [2:0] fb;
    logic [2:0] con;
    logic [6:0] kc;
    logic [5:0] kf;
    logic [1:0] ams;
    logic [2:0] pms;
  } mw_t;

  typedef struct packed {
    logic       busy;
    logic       ovf;
    logic [2:0] slot;
    mw_t        w;
  } obs_t;

  typedef struct {
    logic [1:0] grp;
    int         ch;
    logic [7:0] d;
  } pend_t;

  mw_t        m_mem [8];
  mw_t        m_out;
  logic [2:0] m_slot;
  int         m_ptr;
  bit         m_busy, m_ovf;
  pend_t      m_q[$];
  obs_t       sb[$];

  // Advance the model with the inputs about to be sampled, queue the expected
  // observation, then let the DUT take the same edge.
  task automatic step();
    obs_t  e;
    pend_t p;
    bit    acc;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_out  = '0;
      m_slot = '0;
      m_ptr  = 0;
      m_q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      acc = wr && !m_busy && (int'(wr_ch) < 8);
      if (cen) begin
        if (m_q.size() != 0 && m_q[0].ch == m_ptr) begin
          p = m_q.pop_front();
          case (p.grp)
            2'd0: begin
              m_mem[m_ptr].rl  = p.d[7:6];
              m_mem[m_ptr].fb  = p.d[5:3];
              m_mem[m_ptr].con = p.d[2:0];
            end
            2'd1: m_mem[m_ptr].kc = p.d[6:0];
            2'd2: m_mem[m_ptr].kf = p.d[7:2];
            default: begin
              m_mem[m_ptr].pms = p.d[6:4];
              m_mem[m_ptr].ams = p.d[1:0];
            end
          endcase
        end
        m_out  = m_mem[m_ptr];
        m_slot = 3'(m_ptr);
        m_ptr  = (m_ptr + 1) % 8;
      end
      if (acc) begin
        p.grp = wr_grp;
        p.ch  = int'(wr_ch);
        p.d   = din;
        m_q.push_back(p);
      end else if (wr) begin
        m_ovf = 1'b1;
      end
      m_busy = (m_q.size() == 2);
    end
    e.busy = m_busy;
    e.ovf  = m_ovf;
    e.slot = m_slot;
    e.w    = m_out;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compare every DUT observation against the queued expectation
  always @(posedge clk) begin
    obs_t exp_o, got;
    #1;
    if (sb.size() != 0) begin
      exp_o = sb.pop_front();
      got   = {busy, ovf, slot, rl, fb, con, kc, kf, ams, pms};
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL sb_word t=%0t got=%h expected=%h", $time, got, exp_o);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; cen = 1'b1;
    step(); step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || ovf !== 1'b0 || slot !== 3'd0 || kc !== 7'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b ovf=%b slot=%0d kc=%h expected 0", busy, ovf, slot, kc);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (slot !== 3'(i % 8) || {rl, fb, con, kc, kf, ams, pms} !== 26'd0) begin
        errors++;
        $display("FAIL reset_rotation i=%0d slot=%0d fields=%h expected slot=%0d fields=0",
                 i, slot, {rl, fb, con, kc, kf, ams, pms}, i % 8);
      end
    end
  endtask

  task automatic test_single_write();
    cen = 1'b1;
    step(); step();
    wr = 1'b1; wr_grp = 2'd1; wr_ch = 3'd5; din = 8'h4A;
    step();
    wr = 1'b0;
    step(); step(); step();
    checks++;
    if (slot !== 3'd5 || kc !== 7'h4A) begin
      errors++;
      $display("FAIL single_first slot=%0d kc=%h expected slot=5 kc=4a", slot, kc);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (slot == 3'd5) begin
        if (kc !== 7'h4A) begin
          errors++;
          $display("FAIL single_repeat kc=%h expected 4a", kc);
        end
      end else if (kc !== 7'd0) begin
        errors++;
        $display("FAIL single_other slot=%0d kc=%h expected 0", slot, kc);
      end
    end
    checks++;
    if (slot !== 3'd5) begin
      errors++;
      $display("FAIL single_period slot=%0d expected 5", slot);
    end
  endtask

  task automatic test_field_isolation();
    int seen;
    cen = 1'b0;
    wr = 1'b1; wr_grp = 2'd0; wr_ch = 3'd3; din = 8'hDB;
    step();
    wr_grp = 2'd3; din = 8'h72;
    step();
    wr = 1'b0;
    cen = 1'b1;
    seen = 0;
    for (int i = 0; i < 24 && seen < 2; i++) begin
      step();
      if (slot == 3'd3) begin
        seen++;
        checks++;
        if (seen == 1 && {rl, fb, con, pms, ams} !== {2'd3, 3'd3, 3'd3, 3'd0, 2'd0}) begin
          errors++;
          $display("FAIL iso_first rl=%0d fb=%0d con=%0d pms=%0d ams=%0d expected 3 3 3 0 0",
                   rl, fb, con, pms, ams);
        end
        if (seen == 2 && {rl, fb, con, pms, ams} !== {2'd3, 3'd3, 3'd3, 3'd7, 2'd2}) begin
          errors++;
          $display("FAIL iso_second rl=%0d fb=%0d con=%0d pms=%0d ams=%0d expected 3 3 3 7 2",
                   rl, fb, con, pms, ams);
        end
      end
    end
    checks++;
    if (seen != 2) begin
      errors++;
      $display("FAIL iso_timeout slot3_seen=%0d expected 2", seen);
    end
  endtask

  task automatic test_queue_full();
    int n;
    cen = 1'b0;
    wr = 1'b1; wr_grp = 2'd2; wr_ch = 3'd1; din = 8'hFC;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL qf_busy_one busy=%b expected 0", busy);
    end
    wr_ch = 3'd6; din = 8'h84;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL qf_busy_two busy=%b expected 1", busy);
    end
    wr_grp = 2'd1; wr_ch = 3'd0; din = 8'h11;
    step();
    wr = 1'b0;
    checks++;
    if (ovf !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL qf_drop ovf=%b busy=%b expected ovf=1 busy=1", ovf, busy);
    end
    cen = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 18) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL qf_drain busy=%b expected 0 within 18 cen", busy);
    end
    for (int i = 0; i < 16; i++) step();
  endtask

  task automatic test_bad_channel();
    checks++;
    if (ovf6 !== 1'b0) begin
      errors++;
      $display("FAIL ch6_ovf_init ovf=%b expected 0", ovf6);
    end
    cen6 = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step();
      checks++;
      if (slot6 !== 3'(k % 6)) begin
        errors++;
        $display("FAIL ch6_wrap k=%0d slot=%0d expected %0d", k, slot6, k % 6);
      end
    end
    wr6 = 1'b1; wr_grp6 = 2'd1; wr_ch6 = 3'd6; din6 = 8'h55;
    step();
    wr6 = 1'b0;
    checks++;
    if (ovf6 !== 1'b1 || busy6 !== 1'b0) begin
      errors++;
      $display("FAIL ch6_badch ovf=%b busy=%b expected ovf=1 busy=0", ovf6, busy6);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (kc6 !== 7'd0) begin
        errors++;
        $display("FAIL ch6_nocommit slot=%0d kc=%h expected 0", slot6, kc6);
      end
    end
    cen6 = 1'b0;
  endtask

  task automatic test_reset_mid();
    cen = 1'b0;
    wr = 1'b1; wr_grp = 2'd1; wr_ch = 3'd4; din = 8'h33;
    step();
    wr_grp = 2'd2; din = 8'hF0;
    step();
    wr = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pending busy=%b expected 1", busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || ovf !== 1'b0 || slot !== 3'd0 ||
        {rl, fb, con, kc, kf, ams, pms} !== 26'd0) begin
      errors++;
      $display("FAIL rmid_state busy=%b ovf=%b slot=%0d fields=%h expected all 0",
               busy, ovf, slot, {rl, fb, con, kc, kf, ams, pms});
    end
    cen = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (kc !== 7'd0 || kf !== 6'd0) begin
        errors++;
        $display("FAIL rmid_stale slot=%0d kc=%h kf=%h expected 0", slot, kc, kf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_field_isolation();
    test_queue_full();
    test_bad_channel();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover entries=%0d expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
